// File: rtl/qubit_pkg.sv
// Shared constants and types for the qubit readout pulse path.
// The 5-lane x 16-bit packing matches the rotated-sample bus of the readout integrator.
package qubit_pkg;

    localparam int LANES     = 5;
    localparam int SAMPLE_W  = 16;
    localparam int RAMP_LOG2 = 6;
    localparam int RAMP      = 1 << RAMP_LOG2;
    localparam int LEN_W     = 11;
    localparam int IDX_W     = 14;
    localparam int ENV_W     = RAMP_LOG2 + 1;
    localparam int PROD_W    = SAMPLE_W + RAMP_LOG2 + 1;
    localparam int BUS_W     = LANES * SAMPLE_W;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/readout_pulse_gen_if.sv
// Request/response bundle for the readout pulse generator.
// The master requests pulses; the slave (the generator) drives the packed I/Q words and status.
interface readout_pulse_gen_if;
    import qubit_pkg::*;

    logic             start;
    logic [LEN_W-1:0] pulse_length;
    sample_t          amp_i;
    sample_t          amp_q;
    logic [BUS_W-1:0] data_i;
    logic [BUS_W-1:0] data_q;
    logic             iq_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pulse_length, amp_i, amp_q,
        input  data_i, data_q, iq_valid, busy, done
    );

    modport slave (
        input  start, pulse_length, amp_i, amp_q,
        output data_i, data_q, iq_valid, busy, done
    );

endinterface

// File: rtl/pulse_env_lane.sv
// One output lane: linear ramp envelope for sample n = LANES*w + LANE_IDX, then
// amplitude scaling with floor rounding.
module pulse_env_lane
    import qubit_pkg::*;
#(
    parameter int LANE_IDX = 0
) (
    input  logic             clk100,
    input  logic             reset,
    input  logic [LEN_W-1:0] w_p0,
    input  logic [IDX_W-1:0] n_total,
    input  logic             vld_p1,
    input  sample_t          amp_i,
    input  sample_t          amp_q,
    output sample_t          samp_i_p2,
    output sample_t          samp_q_p2
);

    logic [IDX_W-1:0] n_p0;
    logic [ENV_W-1:0] env_p1;

    // env = min(RAMP, n, N-1-n); n never exceeds N-1 while a word is issued
    function automatic logic [ENV_W-1:0] ramp_env(input logic [IDX_W-1:0] n,
                                                  input logic [IDX_W-1:0] n_tot);
        logic [IDX_W-1:0] tail;
        logic [IDX_W-1:0] m;
        tail = n_tot - n - IDX_W'(1);
        m    = (n < tail) ? n : tail;
        return (m > IDX_W'(RAMP)) ? ENV_W'(RAMP) : m[ENV_W-1:0];
    endfunction

    // env <= RAMP keeps the shifted product inside SAMPLE_W, so no saturation
    function automatic sample_t scale_floor(input sample_t amp, input logic [ENV_W-1:0] env);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(amp) * PROD_W'($signed({1'b0, env}));
        prod = prod >>> RAMP_LOG2;
        return prod[SAMPLE_W-1:0];
    endfunction

    assign n_p0 = IDX_W'(w_p0) * IDX_W'(LANES) + IDX_W'(LANE_IDX);

    // stage 1: envelope
    always_ff @(posedge clk100) begin
        env_p1 <= ramp_env(n_p0, n_total);
    end

    // stage 2: scale, output held at zero between pulses
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            samp_i_p2 <= '0;
            samp_q_p2 <= '0;
        end else if (vld_p1) begin
            samp_i_p2 <= scale_floor(amp_i, env_p1);
            samp_q_p2 <= scale_floor(amp_q, env_p1);
        end else begin
            samp_i_p2 <= '0;
            samp_q_p2 <= '0;
        end
    end

endmodule

// File: rtl/readout_pulse_gen.sv
// Baseband I/Q readout pulse generator: constant complex amplitude under a linear
// ramp-up/ramp-down envelope, 5 samples per clk100 word.
module readout_pulse_gen
    import qubit_pkg::*;
(
    input  logic                clk100,
    input  logic                reset,
    readout_pulse_gen_if.slave  bus
);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] w_p0;
    logic [IDX_W-1:0] n_total;
    sample_t          amp_i_q;
    sample_t          amp_q_q;
    logic             accept;
    logic             vld_p1;
    logic             last_p1;
    logic             vld_p2;
    logic             done_p2;
    logic             busy_q;
    sample_t          samp_i_p2 [LANES];
    sample_t          samp_q_p2 [LANES];
    logic [BUS_W-1:0] data_i_p2;
    logic [BUS_W-1:0] data_q_p2;

    assign accept = (state == IDLE) && bus.start && (bus.pulse_length != '0);

    always_ff @(posedge clk100) begin
        if (accept) begin
            len_q   <= bus.pulse_length;
            n_total <= IDX_W'(bus.pulse_length) * IDX_W'(LANES);
            amp_i_q <= bus.amp_i;
            amp_q_q <= bus.amp_q;
        end
    end

    // FLUSH leaves once the last word is on the outputs, so busy drops with iq_valid
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            w_p0    <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            done_p2 <= 1'b0;
        end else begin
            vld_p1  <= (state == RUN);
            last_p1 <= (state == RUN) && (w_p0 == len_q - LEN_W'(1));
            vld_p2  <= vld_p1;
            done_p2 <= last_p1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        w_p0   <= '0;
                    end
                end
                RUN: begin
                    if (w_p0 == len_q - LEN_W'(1)) begin
                        state <= FLUSH;
                    end else begin
                        w_p0 <= w_p0 + LEN_W'(1);
                    end
                end
                FLUSH: begin
                    if (done_p2) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pulse_env_lane #(
            .LANE_IDX (k)
        ) u_lane (
            .clk100    (clk100),
            .reset     (reset),
            .w_p0      (w_p0),
            .n_total   (n_total),
            .vld_p1    (vld_p1),
            .amp_i     (amp_i_q),
            .amp_q     (amp_q_q),
            .samp_i_p2 (samp_i_p2[k]),
            .samp_q_p2 (samp_q_p2[k])
        );
    end

    always_comb begin
        data_i_p2 = '0;
        data_q_p2 = '0;
        for (int k = 0; k < LANES; k++) begin
            data_i_p2[k*SAMPLE_W +: SAMPLE_W] = samp_i_p2[k];
            data_q_p2[k*SAMPLE_W +: SAMPLE_W] = samp_q_p2[k];
        end
    end

    assign bus.data_i   = data_i_p2;
    assign bus.data_q   = data_q_p2;
    assign bus.iq_valid = vld_p2;
    assign bus.busy     = busy_q;
    assign bus.done     = done_p2;

endmodule
